// File: rtl/io_timer_pkg.sv
// io_timer_pkg: shared constants for the io_timer peripheral.
//   Register word offsets, CTRL/STATUS bit positions, bus widths,
//   default base address and an address-decode helper.
package io_timer_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ADR_W       = 14;  // word address, byte address [15:2]
  localparam int unsigned OFS_W       = 3;
  localparam int unsigned DEF_PRESC_W = 8;

  localparam logic [15:0] DEF_TIMER_BASE = 16'hFC40;

  localparam logic [OFS_W-1:0] OFS_CTRL  = 3'd0;
  localparam logic [OFS_W-1:0] OFS_COUNT = 3'd1;
  localparam logic [OFS_W-1:0] OFS_CMP   = 3'd2;
  localparam logic [OFS_W-1:0] OFS_STAT  = 3'd3;
  localparam logic [OFS_W-1:0] OFS_CAP   = 3'd4;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_IRQ_EN   = 1;
  localparam int unsigned CTRL_AUTO     = 2;
  localparam int unsigned CTRL_PRESC_LO = 8;
  localparam int unsigned CTRL_PRESC_HI = 15;

  localparam int unsigned STAT_MATCH = 0;
  localparam int unsigned STAT_CAP   = 1;

  // Word address falls in the 32-byte window starting at base.
  function automatic logic adr_hit(input logic [ADR_W-1:0] adr,
                                   input logic [15:0]      base);
    return adr[ADR_W-1:OFS_W] == base[15:5];
  endfunction

endpackage

// File: rtl/io_timer_tick.sv
// io_timer_tick: prescaler and tick generator.
//   clk, rst : clock, synchronous active-high reset
//   en       : prescaler runs while high, held at 0 while low
//   presc    : terminal count; tick every presc+1 cycles
//   tick     : combinational, high in the cycle the prescaler hits presc
module io_timer_tick
  import io_timer_pkg::*;
#(
  parameter int unsigned PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q;

  // >= keeps the prescaler from running away if presc is lowered mid-count.
  assign tick = en && (cnt_q >= presc);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/io_timer.sv
// io_timer: memory-mapped 32-bit timer/compare peripheral on the dma_io bus.
//   Registers: CTRL, COUNT, COMPARE, STATUS (W1C), CAPTURE (read-only).
//   Read data joins the daisy chain: dma_io_rdata = hit_q ? rdata_q : dma_io_rdata_in.
//   timer_irq is a registered level interrupt for cpu_top.interrupt_0.
//   Ports: clk, rst (sync active-high), dma_io_we/wadr/wdata (write),
//   dma_io_radr/radr_en (read request), dma_io_rdata_in/rdata (chain),
//   cap_in (capture trigger), timer_irq.
//   Optional capture unit enabled by defining IO_TIMER_CAPTURE_EN.
module io_timer
  import io_timer_pkg::*;
#(
  parameter logic [15:0] TIMER_BASE = DEF_TIMER_BASE,
  parameter int unsigned PRESC_W    = DEF_PRESC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_io_we,
  input  logic [ADR_W-1:0]  dma_io_wadr,
  input  logic [DATA_W-1:0] dma_io_wdata,
  input  logic [ADR_W-1:0]  dma_io_radr,
  input  logic              dma_io_radr_en,
  input  logic [DATA_W-1:0] dma_io_rdata_in,
  output logic [DATA_W-1:0] dma_io_rdata,
  input  logic              cap_in,
  output logic              timer_irq
);

  logic               en_q, irq_en_q, auto_q, match_q;
  logic [PRESC_W-1:0] presc_q;
  logic [DATA_W-1:0]  count_q, cmp_q, rdata_q, rd_val_c;
  logic               hit_q, tick, match_set_c, irq_src_c;
  logic [DATA_W-1:0]  capture_c;
  logic               cap_flag_c;

  // Bus decode.
  logic             wr_hit_c, rd_hit_c;
  logic [OFS_W-1:0] wofs_c, rofs_c;
  assign wr_hit_c = dma_io_we && adr_hit(dma_io_wadr, TIMER_BASE);
  assign rd_hit_c = dma_io_radr_en && adr_hit(dma_io_radr, TIMER_BASE);
  assign wofs_c   = dma_io_wadr[OFS_W-1:0];
  assign rofs_c   = dma_io_radr[OFS_W-1:0];

  logic wr_ctrl_c, wr_count_c, wr_cmp_c, wr_stat_c;
  assign wr_ctrl_c  = wr_hit_c && (wofs_c == OFS_CTRL);
  assign wr_count_c = wr_hit_c && (wofs_c == OFS_COUNT);
  assign wr_cmp_c   = wr_hit_c && (wofs_c == OFS_CMP);
  assign wr_stat_c  = wr_hit_c && (wofs_c == OFS_STAT);

  io_timer_tick #(.PRESC_W(PRESC_W)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (en_q),
    .presc (presc_q),
    .tick  (tick)
  );

  assign match_set_c = tick && (count_q == cmp_q);

  // Control, counter, compare and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      auto_q    <= 1'b0;
      presc_q   <= '0;
      count_q   <= '0;
      cmp_q     <= '0;
      match_q   <= 1'b0;
      timer_irq <= 1'b0;
    end else begin
      if (wr_ctrl_c) begin
        en_q     <= dma_io_wdata[CTRL_EN];
        irq_en_q <= dma_io_wdata[CTRL_IRQ_EN];
        auto_q   <= dma_io_wdata[CTRL_AUTO];
        presc_q  <= dma_io_wdata[CTRL_PRESC_LO +: PRESC_W];
      end
      // Bus write beats a same-cycle tick.
      if (wr_count_c) begin
        count_q <= dma_io_wdata;
      end else if (tick) begin
        count_q <= (match_set_c && auto_q) ? '0 : count_q + DATA_W'(1);
      end
      if (wr_cmp_c) begin
        cmp_q <= dma_io_wdata;
      end
      // Set beats a same-cycle W1C.
      if (match_set_c) begin
        match_q <= 1'b1;
      end else if (wr_stat_c && dma_io_wdata[STAT_MATCH]) begin
        match_q <= 1'b0;
      end
      timer_irq <= irq_src_c && irq_en_q;
    end
  end

`ifdef IO_TIMER_CAPTURE_EN
  logic              cap_s1_q, cap_s2_q, cap_s3_q, cap_flag_q;
  logic [DATA_W-1:0] capture_q;
  logic              cap_edge_c;

  assign cap_edge_c = cap_s2_q && !cap_s3_q;

  // Two-flop synchronizer, edge detect, capture register and flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_s1_q   <= 1'b0;
      cap_s2_q   <= 1'b0;
      cap_s3_q   <= 1'b0;
      cap_flag_q <= 1'b0;
      capture_q  <= '0;
    end else begin
      cap_s1_q <= cap_in;
      cap_s2_q <= cap_s1_q;
      cap_s3_q <= cap_s2_q;
      if (cap_edge_c) begin
        capture_q  <= count_q;
        cap_flag_q <= 1'b1;
      end else if (wr_stat_c && dma_io_wdata[STAT_CAP]) begin
        cap_flag_q <= 1'b0;
      end
    end
  end

  assign capture_c  = capture_q;
  assign cap_flag_c = cap_flag_q;
`else
  logic unused_cap_in;
  assign unused_cap_in = cap_in;
  assign capture_c     = '0;
  assign cap_flag_c    = 1'b0;
`endif

  assign irq_src_c = match_q || cap_flag_c;

  // Register read mux; offsets 5-7 read 0.
  always_comb begin
    rd_val_c = '0;
    case (rofs_c)
      OFS_CTRL: begin
        rd_val_c[CTRL_EN]                   = en_q;
        rd_val_c[CTRL_IRQ_EN]               = irq_en_q;
        rd_val_c[CTRL_AUTO]                 = auto_q;
        rd_val_c[CTRL_PRESC_LO +: PRESC_W]  = presc_q;
      end
      OFS_COUNT: rd_val_c = count_q;
      OFS_CMP:   rd_val_c = cmp_q;
      OFS_STAT: begin
        rd_val_c[STAT_MATCH] = match_q;
        rd_val_c[STAT_CAP]   = cap_flag_c;
      end
      OFS_CAP:   rd_val_c = capture_c;
      default:   rd_val_c = '0;
    endcase
  end

  // One-cycle read pipeline into the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      hit_q <= rd_hit_c;
      if (rd_hit_c) begin
        rdata_q <= rd_val_c;
      end
    end
  end

  assign dma_io_rdata = hit_q ? rdata_q : dma_io_rdata_in;

endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: directed bench for io_timer with a read-data scoreboard.
//   Reads push their expected value; a monitor pops and compares in the
//   cycle the read data appears on dma_io_rdata.
module tb_io_timer;
  import io_timer_pkg::*;

  localparam logic [13:0] BASE_W = DEF_TIMER_BASE[15:2];
  localparam logic [13:0] MISS_W = 14'h3F00;

  logic        clk = 1'b0;
  logic        rst;
  logic        dma_io_we;
  logic [13:0] dma_io_wadr;
  logic [31:0] dma_io_wdata;
  logic [13:0] dma_io_radr;
  logic        dma_io_radr_en;
  logic [31:0] dma_io_rdata_in;
  logic [31:0] dma_io_rdata;
  logic        cap_in;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic        rd_fire = 1'b0;

  always #5 clk = ~clk;

  io_timer dut (
    .clk             (clk),
    .rst             (rst),
    .dma_io_we       (dma_io_we),
    .dma_io_wadr     (dma_io_wadr),
    .dma_io_wdata    (dma_io_wdata),
    .dma_io_radr     (dma_io_radr),
    .dma_io_radr_en  (dma_io_radr_en),
    .dma_io_rdata_in (dma_io_rdata_in),
    .dma_io_rdata    (dma_io_rdata),
    .cap_in          (cap_in),
    .timer_irq       (timer_irq)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  // Monitor: a read accepted at a posedge shows its data in the following cycle.
  always @(posedge clk) rd_fire <= dma_io_radr_en;

  always @(negedge clk) begin
    if (rd_fire) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %h with empty scoreboard", dma_io_rdata);
      end else begin
        chk(nm_q.pop_front(), dma_io_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_raw(input logic [13:0] a, input logic [31:0] d);
    dma_io_we    = 1'b1;
    dma_io_wadr  = a;
    dma_io_wdata = d;
    step();
    dma_io_we    = 1'b0;
  endtask

  task automatic wr(input logic [2:0] ofs, input logic [31:0] d);
    wr_raw(BASE_W + 14'(ofs), d);
  endtask

  task automatic rd_raw(input logic [13:0] a, input logic [31:0] e, input string n);
    dma_io_radr    = a;
    dma_io_radr_en = 1'b1;
    exp_q.push_back(e);
    nm_q.push_back(n);
    step();
    dma_io_radr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] ofs, input logic [31:0] e, input string n);
    rd_raw(BASE_W + 14'(ofs), e, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_cap, exp_stat, exp_irq;
`ifdef IO_TIMER_CAPTURE_EN
    exp_cap  = 32'd42;
    exp_stat = 32'h2;
    exp_irq  = 32'h1;
`else
    exp_cap  = 32'd0;
    exp_stat = 32'h0;
    exp_irq  = 32'h0;
`endif
    rst = 1'b1; dma_io_we = 1'b0; dma_io_wadr = '0; dma_io_wdata = '0;
    dma_io_radr = '0; dma_io_radr_en = 1'b0;
    dma_io_rdata_in = 32'hDEADBEEF; cap_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and chain pass-through.
    chk("rst_irq", {31'b0, timer_irq}, 32'h0);
    chk("idle_passthru", dma_io_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) rd(3'(i), 32'h0, $sformatf("rst_reg%0d", i));
    rd(3'd5, 32'h0, "rsvd5");

    // Prescaled compare with auto-reload and interrupt.
    wr(OFS_CMP, 32'd5);
    wr(OFS_CTRL, 32'h0000_0307);            // cycle 0: EN active
    repeat (23) step();                     // cycle 23: 6th tick, match pending
    chk("irq_pre_match", {31'b0, timer_irq}, 32'h0);
    step();                                 // cycle 24: MATCH=1, irq not yet
    chk("irq_match_cycle", {31'b0, timer_irq}, 32'h0);
    rd(OFS_STAT, 32'h1, "match_set");       // now cycle 25
    chk("irq_rise", {31'b0, timer_irq}, 32'h1);
    rd(OFS_COUNT, 32'h0, "auto_reload");    // now cycle 26
    wr(OFS_STAT, 32'h1);                    // MATCH clears, irq one cycle later
    chk("irq_hold", {31'b0, timer_irq}, 32'h1);
    step();
    chk("irq_clear", {31'b0, timer_irq}, 32'h0);
    wr(OFS_CTRL, 32'h0);

    // Wrap at 2^32 with PRESC=0, no auto-reload.
    wr(OFS_CMP, 32'h10);
    wr(OFS_COUNT, 32'hFFFF_FFFE);
    wr(OFS_CTRL, 32'h1);                    // cycle 0
    rd(OFS_COUNT, 32'hFFFF_FFFE, "wrap_fffe");
    rd(OFS_COUNT, 32'hFFFF_FFFF, "wrap_ffff");
    rd(OFS_COUNT, 32'h0, "wrap_0");
    rd(OFS_COUNT, 32'h1, "wrap_1");
    rd(OFS_STAT, 32'h0, "no_match_wrap");   // now cycle 5
    repeat (13) step();                     // cycle 18: COUNT=0x10
    rd(OFS_STAT, 32'h0, "match_not_yet");
    rd(OFS_STAT, 32'h1, "match_at_10");
    rd(OFS_COUNT, 32'h12, "count_no_reload");  // now cycle 21

    // Collisions: COUNT write vs tick, W1C vs match set.
    wr(OFS_COUNT, 32'h100);
    rd(OFS_COUNT, 32'h100, "wr_beats_tick");   // now cycle 23
    wr(OFS_CMP, 32'h110);
    wr(OFS_STAT, 32'h1);
    rd(OFS_STAT, 32'h0, "w1c_clear");          // now cycle 26
    repeat (12) step();                        // cycle 38: COUNT=0x110
    wr(OFS_STAT, 32'h1);
    rd(OFS_STAT, 32'h1, "set_beats_w1c");
    chk("irq_gated_off", {31'b0, timer_irq}, 32'h0);
    wr(OFS_CTRL, 32'h0);                       // last tick: 0x112 -> 0x113
    repeat (3) step();
    rd(OFS_COUNT, 32'h113, "frozen_en0");

    // Read pipeline timing, chain pass-through and misses.
    wr(OFS_CMP, 32'hA5A5);
    rd(OFS_CMP, 32'hA5A5, "cmp_read");
    step();
    chk("hit_drops", dma_io_rdata, 32'hDEADBEEF);
    rd(OFS_CMP, 32'hA5A5, "cmp_b2b");
    rd_raw(MISS_W, 32'hDEADBEEF, "miss_b2b");
    wr_raw(MISS_W + 14'(OFS_CMP), 32'h1);
    dma_io_rdata_in = 32'h1234_5678;
    step();
    chk("passthru_new", dma_io_rdata, 32'h1234_5678);
    rd(OFS_CMP, 32'hA5A5, "miss_write_ignored");

    // Capture input (expectations depend on the build).
    wr(OFS_STAT, 32'h3);
    wr(OFS_COUNT, 32'h0);
    wr(OFS_CTRL, 32'h3);                    // cycle 0, COUNT=0
    repeat (40) step();                     // cycle 40: COUNT=40
    cap_in = 1'b1;
    step();
    step();
    cap_in = 1'b0;
    repeat (3) step();
    rd(OFS_CAP, exp_cap, "capture");
    rd(OFS_STAT, exp_stat, "cap_flag");
    chk("cap_irq", {31'b0, timer_irq}, exp_irq);
    rd(OFS_CTRL, 32'h3, "ctrl_readback");
    wr(OFS_CTRL, 32'h0);

    repeat (3) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
